and_or_sched: RTL and testbench

AND_OR_SCHED -- requirements
Module: and_or_sched

---
 rtl/and_or_sched_pkg.sv | 15 +
 rtl/and_or_reg.sv | 20 ++
 rtl/and_or_sched.sv | 128 ++++++++++++
 tb/tb_and_or_sched.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/and_or_sched_pkg.sv
// Shared definitions for the two-requester AND-OR scheduler:
// FSM state encodings, requester ids and operand width.
package and_or_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic ID0   = 1'b0;
    localparam logic ID1   = 1'b1;
    localparam int   OPS_W = 4;

endpackage

// File: rtl/and_or_reg.sv
// Registered AND-OR datapath: f <= (a & b) | (c & d) on every rising edge.
module and_or_reg (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f
);

    always_ff @(posedge clk) begin
        if (rst) begin
            f <= 1'b0;
        end else begin
            f <= (a & b) | (c & d);
        end
    end

endmodule

// File: rtl/and_or_sched.sv
// Two-requester arbiter with burst-limited fairness feeding one shared AND-OR
// datapath; one operation every three cycles (IDLE -> ISSUE -> CAPTURE).
module and_or_sched
    import and_or_sched_pkg::*;
#(
    parameter int BURST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [OPS_W-1:0] ops0,
    input  logic             req1,
    input  logic [OPS_W-1:0] ops1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             res_valid,
    output logic             res_id,
    output logic             res_f,
    output logic             busy
);

    localparam logic [2:0] BURST_L = 3'(BURST);

    state_t           state;
    state_t           state_nx;
    logic [OPS_W-1:0] opr_p0;
    logic             owner;
    logic             last;
    logic [2:0]       run;
    logic             win;
    logic             f_p1;

    // run == 0 means no grant since reset, so the first tie goes to the id
    // opposite last-granted (requester 0).
    function automatic logic pick_winner(input logic r0, input logic r1,
                                         input logic l, input logic [2:0] n);
        logic w;
        if (r0 && r1) begin
            w = ((n != 3'd0) && (n < BURST_L)) ? l : ~l;
        end else if (r1) begin
            w = ID1;
        end else begin
            w = ID0;
        end
        return w;
    endfunction

    function automatic logic [2:0] next_run(input logic w, input logic l,
                                            input logic [2:0] n);
        logic [2:0] r;
        if (w != l) begin
            r = 3'd1;
        end else if (n == 3'd7) begin
            r = 3'd7;
        end else begin
            r = n + 3'd1;
        end
        return r;
    endfunction

    assign win = pick_winner(req0, req1, last, run);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req0 || req1) state_nx = ISSUE;
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Arbitration and operand capture happen only on the IDLE -> ISSUE edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            opr_p0 <= '0;
            owner  <= ID0;
            last   <= ID1;
            run    <= 3'd0;
        end else if (state == IDLE && (req0 || req1)) begin
            opr_p0 <= win ? ops1 : ops0;
            owner  <= win;
            last   <= win;
            run    <= next_run(win, last, run);
        end
    end

    // ---- stage p0 -> p1: operands registered through the shared datapath
    and_or_reg u_and_or_reg (
        .clk (clk),
        .rst (rst),
        .a   (opr_p0[3]),
        .b   (opr_p0[2]),
        .c   (opr_p0[1]),
        .d   (opr_p0[0]),
        .f   (f_p1)
    );

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        res_valid = 1'b0;
        res_id    = 1'b0;
        res_f     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            ISSUE: begin
                gnt0 = (owner == ID0);
                gnt1 = (owner == ID1);
            end
            CAPTURE: begin
                res_valid = 1'b1;
                res_id    = owner;
                res_f     = f_p1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_and_or_sched.sv
// Directed self-checking bench for and_or_sched: reset, single request,
// round-robin, burst arbitration, reset abort and late request.
module tb_and_or_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] ops0, ops1;

    logic a_gnt0, a_gnt1, a_vld, a_id, a_f, a_busy;
    logic b_gnt0, b_gnt1, b_vld, b_id, b_f, b_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    and_or_sched #(.BURST(1)) dut_rr (
        .clk(clk), .rst(rst),
        .req0(req0), .ops0(ops0), .req1(req1), .ops1(ops1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .res_valid(a_vld),
        .res_id(a_id), .res_f(a_f), .busy(a_busy)
    );

    and_or_sched #(.BURST(2)) dut_b2 (
        .clk(clk), .rst(rst),
        .req0(req0), .ops0(ops0), .req1(req1), .ops1(ops1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .res_valid(b_vld),
        .res_id(b_id), .res_f(b_f), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later; grant exclusivity is checked every cycle.
    task automatic step();
        @(posedge clk);
        #1;
        chk("excl_rr", 8'((a_gnt0 & a_gnt1) | (a_vld & (a_gnt0 | a_gnt1))), 8'd0);
        chk("excl_b2", 8'((b_gnt0 & b_gnt1) | (b_vld & (b_gnt0 | b_gnt1))), 8'd0);
    endtask

    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Outputs of the BURST=1 instance packed {gnt0,gnt1,vld,id,f,busy}.
    function automatic logic [7:0] rr_out();
        return {2'b00, a_gnt0, a_gnt1, a_vld, a_id, a_f, a_busy};
    endfunction

    logic exp_id;
    logic seq2 [6];

    initial begin
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        ops0 = 4'b0000;
        ops1 = 4'b0000;

        // Reset and idle behaviour
        step();
        step();
        chk("rst_rr_outs", rr_out(), 8'h00);
        chk("rst_b2_busy", 8'(b_busy), 8'h00);
        rst = 1'b0;
        step();
        chk("idle_outs_1", rr_out(), 8'h00);
        step();
        chk("idle_outs_2", rr_out(), 8'h00);

        // Single request from requester 0: f = (1&1)|(0&0) = 1
        req0 = 1'b1;
        ops0 = 4'b1100;
        step();
        chk("single_issue", rr_out(), 8'b0010_0001);
        req0 = 1'b0;
        step();
        chk("single_capture", rr_out(), 8'b0000_1011);
        step();
        chk("single_done", rr_out(), 8'h00);

        // Strict round-robin: 0,1,0,1 with f=0 for id 0 and f=1 for id 1
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        ops0 = 4'b0101;
        ops1 = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 1);
            step();
            chk($sformatf("rr_gnt0_%0d", i), 8'(a_gnt0), 8'(!exp_id));
            chk($sformatf("rr_gnt1_%0d", i), 8'(a_gnt1), 8'(exp_id));
            step();
            chk($sformatf("rr_vld_%0d", i), 8'(a_vld), 8'd1);
            chk($sformatf("rr_id_%0d", i), 8'(a_id), 8'(exp_id));
            chk($sformatf("rr_f_%0d", i), 8'(a_f), 8'(exp_id));
            step();
        end

        // Burst of two: 0,0,1,1,0,0 on the BURST=2 instance
        do_reset();
        seq2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("b2_gnt_%0d", i), {6'd0, b_gnt0, b_gnt1}, {6'd0, !seq2[i], seq2[i]});
            step();
            chk($sformatf("b2_res_%0d", i), {6'd0, b_vld, b_id}, {6'd0, 1'b1, seq2[i]});
            step();
        end

        // Reset in ISSUE aborts the operation; requester is re-granted
        do_reset();
        req0 = 1'b1;
        ops0 = 4'b1100;
        step();
        chk("abort_issue", rr_out(), 8'b0010_0001);
        rst = 1'b1;
        step();
        chk("abort_outs", rr_out(), 8'h00);
        rst = 1'b0;
        step();
        chk("abort_regrant", rr_out(), 8'b0010_0001);
        req0 = 1'b0;
        step();
        chk("abort_result", rr_out(), 8'b0000_1011);
        step();

        // Late request from requester 1 waits for IDLE; f1 = (0&1)|(1&1) = 1
        req0 = 1'b1;
        ops0 = 4'b0011;
        step();
        chk("late_issue0", rr_out(), 8'b0010_0001);
        req0 = 1'b0;
        req1 = 1'b1;
        ops1 = 4'b0111;
        step();
        chk("late_capture0", rr_out(), 8'b0000_1011);
        step();
        chk("late_idle", rr_out(), 8'h00);
        step();
        chk("late_issue1", rr_out(), 8'b0001_0001);
        req1 = 1'b0;
        step();
        chk("late_capture1", rr_out(), 8'b0000_1111);
        step();
        chk("late_done", rr_out(), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
